// File: rtl/nw_pkg.sv
// Shared types and sizes for the NW grid host.
// Score entries carry the job-last flag with the raw score.
package nw_pkg;

  localparam int S_LEN    = 64;
  localparam int C_WIDTH  = 2;
  localparam int S_WIDTH  = 8;
  localparam int STR_W    = S_LEN * C_WIDTH;
  localparam int PAIR_W   = 2 * STR_W;
  localparam int IN_W_DEF = 64;
  localparam int BEATS    = PAIR_W / IN_W_DEF;

  typedef struct packed {
    logic                      last;
    logic signed [S_WIDTH-1:0] score;
  } score_entry_t;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_EMIT = 1'b1
  } pk_state_t;

endpackage

// File: rtl/nw_score_fifo.sv
// Score FIFO between grid capture and output packer.
// Push and pop may coincide, including when full.
module nw_score_fifo
  import nw_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  score_entry_t           i_wdata,
  input  logic                   i_pop,
  output score_entry_t           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  score_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/nw_grid_host.sv
// Host side of the NW grid: deserialise pairs, issue,
// capture scores under credit control, pack output beats.
module nw_grid_host
  import nw_pkg::*;
#(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_last,
  output logic                      grid_valid_in,
  output logic [STR_W-1:0]          grid_t_str,
  output logic [STR_W-1:0]          grid_l_str,
  input  logic                      grid_valid_out,
  input  logic signed [S_WIDTH-1:0] grid_score,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_last,
  output logic                      err_spurious
);

  localparam int N_BEATS = PAIR_W / IN_W;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int LANES   = OUT_W / S_WIDTH;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  logic [BW-1:0]     r_beat;
  logic [PAIR_W-1:0] r_asm;
  logic              r_issue;
  logic              r_issue_last;
  logic [STR_W-1:0]  r_t;
  logic [STR_W-1:0]  r_l;
  logic [S_LEN-1:0]  r_dly;
  logic [CW-1:0]     r_credits;
  logic [CW-1:0]     r_inflight;
  logic              r_err;
  pk_state_t         r_state;
  pk_state_t         w_next;
  logic [LW-1:0]     r_lane;
  logic [OUT_W-1:0]  r_odata;
  logic              r_olast;

  logic              w_accept;
  logic              w_final;
  logic              w_fire;
  logic              w_cap;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_fifo_cnt;
  logic              w_unused;
  logic [PAIR_W-1:0] w_pair;
  score_entry_t      w_wdata;
  score_entry_t      w_rdata;

  assign w_final  = (r_beat == BW'(N_BEATS - 1));
  assign in_ready = ~w_final | (r_credits != '0);
  assign w_accept = in_valid & in_ready;
  assign w_fire   = w_accept & w_final;
  assign w_cap    = grid_valid_out & (r_inflight != '0);
  assign w_wdata  = '{last: r_dly[S_LEN-1], score: grid_score};
  assign w_unused = &{1'b0, w_fifo_cnt, w_full};

  assign grid_valid_in = r_issue;
  assign grid_t_str    = r_t;
  assign grid_l_str    = r_l;
  assign out_data      = r_odata;
  assign out_last      = r_olast;
  assign err_spurious  = r_err;

  // full pair as it will look once the current beat lands
  always_comb begin
    w_pair = r_asm;
    w_pair[r_beat*IN_W +: IN_W] = in_data;
  end

  // deserialiser: beat counter and assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_asm  <= '0;
    end else if (w_accept) begin
      r_asm  <= w_pair;
      r_beat <= w_final ? '0 : r_beat + 1'b1;
    end
  end

  // issue register: one-cycle strobe, strings held after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue      <= 1'b0;
      r_issue_last <= 1'b0;
      r_t          <= '0;
      r_l          <= '0;
    end else begin
      r_issue <= w_fire;
      if (w_fire) begin
        r_t          <= w_pair[STR_W-1:0];
        r_l          <= w_pair[PAIR_W-1:STR_W];
        r_issue_last <= in_last;
      end
    end
  end

  // last flag follows the pair through the grid latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dly <= '0;
    else        r_dly <= {r_dly[S_LEN-2:0], r_issue & r_issue_last};
  end

  // credit and inflight accounting; a slot is reserved as
  // soon as the final beat is taken, the strobe follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits  <= CW'(FIFO_DEPTH);
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case ({w_fire, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
      unique case ({w_fire, w_cap})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      if (grid_valid_out && r_inflight == '0) r_err <= 1'b1;
    end
  end

  nw_score_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cap),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  // packer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PK_FILL;
    else        r_state <= w_next;
  end

  // packer next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      PK_FILL:
        if (w_pop && (r_lane == LW'(LANES - 1) || w_rdata.last))
          w_next = PK_EMIT;
      PK_EMIT:
        if (out_ready) w_next = PK_FILL;
      default: w_next = PK_FILL;
    endcase
  end

  // packer outputs
  always_comb begin
    w_pop     = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (r_state == PK_FILL): w_pop     = ~w_empty;
      (r_state == PK_EMIT): out_valid = 1'b1;
      default: ;
    endcase
  end

  // packer lane datapath; lanes cleared after each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_odata <= '0;
      r_olast <= 1'b0;
    end else if (w_pop) begin
      r_odata[r_lane*S_WIDTH +: S_WIDTH] <= w_rdata.score;
      r_lane  <= r_lane + 1'b1;
      r_olast <= w_rdata.last;
    end else if (out_valid && out_ready) begin
      r_lane  <= '0;
      r_odata <= '0;
      r_olast <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nw_grid_host.sv
// Bench for nw_grid_host: NW grid model, expected-score
// queue and a per-cycle output compare process.
module tb_nw_grid_host;
  import nw_pkg::*;

  localparam int IN_W  = 64;
  localparam int OUT_W = 64;
  localparam int FD    = 16;
  localparam int LANES = OUT_W / S_WIDTH;
  localparam int NB    = PAIR_W / IN_W;
  localparam int BOUND = 5000;

  typedef struct {
    logic       last;
    logic [7:0] s;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_last;
  logic [IN_W-1:0] in_data;
  logic grid_valid_in, grid_valid_out;
  logic [STR_W-1:0] grid_t_str, grid_l_str;
  logic signed [S_WIDTH-1:0] grid_score;
  logic out_valid, out_last, err_spurious;
  logic out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic force_gvo = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;
  int n_issue = 0;
  int mode = 0;
  logic exp_err = 1'b0;
  ent_t q[$];
  logic [OUT_W:0] beats[$];

  always #5 clk = ~clk;

  nw_grid_host #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .grid_valid_in(grid_valid_in),
    .grid_t_str(grid_t_str), .grid_l_str(grid_l_str),
    .grid_valid_out(grid_valid_out), .grid_score(grid_score),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .err_spurious(err_spurious)
  );

  // Needleman-Wunsch, match +1, mismatch -1, gap -1
  function automatic logic [7:0] nw_score(
    input logic [STR_W-1:0] t, input logic [STR_W-1:0] l);
    int prv[S_LEN+1];
    int cur[S_LEN+1];
    int d, u, lf, m;
    for (int j = 0; j <= S_LEN; j++) prv[j] = -j;
    for (int i = 1; i <= S_LEN; i++) begin
      cur[0] = -i;
      for (int j = 1; j <= S_LEN; j++) begin
        d = prv[j-1] + ((l[(i-1)*C_WIDTH +: C_WIDTH] ==
                         t[(j-1)*C_WIDTH +: C_WIDTH]) ? 1 : -1);
        u  = prv[j] - 1;
        lf = cur[j-1] - 1;
        m  = d;
        if (u > m) m = u;
        if (lf > m) m = lf;
        cur[j] = m;
      end
      prv = cur;
    end
    return 8'(prv[S_LEN]);
  endfunction

  function automatic logic [STR_W-1:0] rand_str();
    logic [STR_W-1:0] s;
    for (int k = 0; k < STR_W / 32; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  // grid: fixed S_LEN-cycle latency, reset with host reset
  logic [S_LEN-1:0] pv;
  logic [S_LEN*S_WIDTH-1:0] ps;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      ps <= '0;
    end else begin
      pv <= {pv[S_LEN-2:0], grid_valid_in};
      ps <= {ps[(S_LEN-1)*S_WIDTH-1:0],
             grid_valid_in ? nw_score(grid_t_str, grid_l_str) : 8'h00};
    end
  end
  assign grid_valid_out = pv[S_LEN-1] | force_gvo;
  assign grid_score = ps[S_LEN*S_WIDTH-1 -: S_WIDTH];

  task automatic chk(input string nm,
                     input logic [PAIR_W-1:0] act,
                     input logic [PAIR_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d,
                           input logic lst, output bit ok);
    bit r;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = lst;
    for (int n = 0; n < BOUND; n++) begin
      r = in_ready;
      if (!r) stalls++;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
      #1;
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) chk("in_ready timeout", 0, 1);
  endtask

  task automatic send_pair(input logic [STR_W-1:0] t,
                           input logic [STR_W-1:0] l,
                           input logic last, input int gap);
    logic [PAIR_W-1:0] p;
    ent_t e;
    bit ok;
    p = {l, t};
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk);
        #1;
      end
      send_beat(p[b*IN_W +: IN_W],
                (b == NB - 1) ? last : 1'($urandom_range(0, 1)), ok);
      if (!ok) return;
    end
    e.last = last;
    e.s = nw_score(t, l);
    q.push_back(e);
    chk("issue strobe", PAIR_W'(grid_valid_in), 1);
    chk("issue strings", {grid_l_str, grid_t_str}, p);
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (beats.size() < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("beat count", beats.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [STR_W-1:0] lp;
    int base, c;
    bit quiet;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;

    fork
      // out_ready policy: 0 always ready, 1 stalled, 2 random
      forever begin
        @(posedge clk);
        #1;
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = 1'b0;
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
      forever begin
        @(negedge clk);
        if (grid_valid_in) n_issue++;
      end
      // compare process: status every cycle, beats on handshake
      begin : cmp
        ent_t e;
        logic [OUT_W-1:0] d;
        logic lst;
        int n;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            chk("err_spurious", PAIR_W'(err_spurious), PAIR_W'(exp_err));
            if (out_valid && out_ready) begin
              chk("beat expected", PAIR_W'(q.size() > 0), 1);
              d = '0;
              lst = 1'b0;
              n = 0;
              while (n < LANES && q.size() > 0) begin
                e = q.pop_front();
                d[n*S_WIDTH +: S_WIDTH] = e.s;
                lst = e.last;
                n++;
                if (e.last) break;
              end
              chk("beat data", out_data, d);
              chk("beat last", PAIR_W'(out_last), PAIR_W'(lst));
              beats.push_back({out_last, out_data});
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst out_valid", PAIR_W'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", PAIR_W'(out_last), 0);
    chk("rst grid_valid_in", PAIR_W'(grid_valid_in), 0);
    chk("rst in_ready", PAIR_W'(in_ready), 1);
    chk("rst err", PAIR_W'(err_spurious), 0);

    // single all-A pair: score 64 in lane 0
    mode = 0;
    beats.delete();
    send_pair('0, '0, 1'b1, 0);
    wait_beats(1);
    chk("single data", beats[0][OUT_W-1:0], 64'h40);
    chk("single last", beats[0][OUT_W], 1);

    // 8 pairs, pair i has i mismatching chars: 64-2i
    beats.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      lp = '0;
      for (int k = 0; k < i; k++) lp[k*C_WIDTH +: C_WIDTH] = 2'b01;
      send_pair('0, lp, i == 7, 0);
    end
    wait_beats(1);
    chk("eight data", beats[0][OUT_W-1:0], 64'h32343638_3A3C3E40);
    chk("eight last", beats[0][OUT_W], 1);
    chk("eight stalls", stalls, 0);

    // 11-pair job splits into 8 lanes + 3 lanes
    beats.delete();
    for (int i = 0; i < 11; i++) send_pair('0, '0, i == 10, 1);
    wait_beats(2);
    chk("job11 b0 data", beats[0][OUT_W-1:0], 64'h40404040_40404040);
    chk("job11 b0 last", beats[0][OUT_W], 0);
    chk("job11 b1 data", beats[1][OUT_W-1:0], 64'h00000000_00404040);
    chk("job11 b1 last", beats[1][OUT_W], 1);

    // output stalled: FIFO plus the packer's lane register
    // hold all issued pairs; the rest wait at a final beat
    beats.delete();
    mode = 1;
    base = n_issue;
    fork
      for (int i = 0; i < 40; i++)
        send_pair(rand_str(), rand_str(), i == 39, 0);
      begin
        repeat (2000) @(posedge clk);
        #1;
        chk("stall issued", n_issue - base, FD + LANES);
        chk("stall in_ready", PAIR_W'(in_ready), 0);
        mode = 0;
      end
    join
    wait_beats(5);

    // reset with 3 pairs inside the grid
    for (int i = 0; i < 3; i++)
      send_pair(rand_str(), rand_str(), i == 2, 0);
    repeat (10) @(posedge clk);
    beats.delete();
    do_reset();
    quiet = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("quiet after reset", PAIR_W'(quiet), 1);
    chk("err after reset", PAIR_W'(err_spurious), 0);
    for (int i = 0; i < 5; i++)
      send_pair(rand_str(), rand_str(), i == 4, 0);
    wait_beats(1);

    // random traffic with random output backpressure
    beats.delete();
    mode = 2;
    for (int i = 0; i < 60; i++)
      send_pair(rand_str(), rand_str(),
                (i == 59) || ($urandom_range(0, 4) == 0), 2);
    mode = 0;
    c = 0;
    while ((q.size() != 0 || out_valid) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("random drained", q.size(), 0);

    // spurious result with nothing in flight
    repeat (80) @(posedge clk);
    #1;
    force_gvo = 1'b1;
    @(posedge clk);
    #1;
    force_gvo = 1'b0;
    exp_err = 1'b1;
    repeat (5) @(posedge clk);
    beats.delete();
    send_pair('0, '0, 1'b1, 0);
    wait_beats(1);
    chk("spurious dropped", beats[0][OUT_W-1:0], 64'h40);
    chk("spurious err", PAIR_W'(err_spurious), 1);
    do_reset();
    @(negedge clk);
    chk("err cleared", PAIR_W'(err_spurious), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
